lint_2_axi_mo: RTL

Multiple-outstanding bridge from one 32-bit lint (TCDM-style) initiator port to an AXI4 manager port of width DATA_WIDTH. It sits at the L2 interconnect boundary, where single-outstanding bridges stall the cluster. A tracking FIFO lets up to MAX_OUTSTANDING transactions be in flight, and responses return to lint strictly in issue order. Each transaction remains a single-beat AXI access.

---
 rtl/lint_2_axi_mo_if.sv | 102 ++++++++++
 rtl/lint_2_axi_mo.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/lint_2_axi_mo_if.sv
// Bus bundles for the lint-to-AXI bridge: the lint initiator port and the AXI4 manager port.
// Signal names keep the bridge-side direction suffixes so both ends read the same.
interface lint_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int BE_WIDTH   = 4,
   parameter int ID_WIDTH   = 16,
   parameter int AUX_WIDTH  = 10
);
   logic                  data_req_i;
   logic [ADDR_WIDTH-1:0] data_addr_i;
   logic                  data_we_i;
   logic [31:0]           data_wdata_i;
   logic [BE_WIDTH-1:0]   data_be_i;
   logic [ID_WIDTH-1:0]   data_ID_i;
   logic [AUX_WIDTH-1:0]  data_aux_i;
   logic                  data_gnt_o;
   logic                  data_rvalid_o;
   logic [31:0]           data_rdata_o;
   logic                  data_ropc_o;
   logic [ID_WIDTH-1:0]   data_rID_o;
   logic [AUX_WIDTH-1:0]  data_raux_o;

   modport master (
      output data_req_i, data_addr_i, data_we_i, data_wdata_i, data_be_i, data_ID_i, data_aux_i,
      input  data_gnt_o, data_rvalid_o, data_rdata_o, data_ropc_o, data_rID_o, data_raux_o
   );
   modport slave (
      input  data_req_i, data_addr_i, data_we_i, data_wdata_i, data_be_i, data_ID_i, data_aux_i,
      output data_gnt_o, data_rvalid_o, data_rdata_o, data_ropc_o, data_rID_o, data_raux_o
   );
endinterface

interface axi_if #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 64,
   parameter int USER_WIDTH   = 10,
   parameter int AXI_ID_WIDTH = 5
);
   logic [AXI_ID_WIDTH-1:0] aw_id_o;
   logic [ADDR_WIDTH-1:0]   aw_addr_o;
   logic [7:0]              aw_len_o;
   logic [2:0]              aw_size_o;
   logic [1:0]              aw_burst_o;
   logic                    aw_lock_o;
   logic [3:0]              aw_cache_o;
   logic [2:0]              aw_prot_o;
   logic [3:0]              aw_region_o;
   logic [3:0]              aw_qos_o;
   logic [USER_WIDTH-1:0]   aw_user_o;
   logic                    aw_valid_o;
   logic                    aw_ready_i;
   logic [DATA_WIDTH-1:0]   w_data_o;
   logic [DATA_WIDTH/8-1:0] w_strb_o;
   logic                    w_last_o;
   logic [USER_WIDTH-1:0]   w_user_o;
   logic                    w_valid_o;
   logic                    w_ready_i;
   logic [AXI_ID_WIDTH-1:0] b_id_i;
   logic [1:0]              b_resp_i;
   logic [USER_WIDTH-1:0]   b_user_i;
   logic                    b_valid_i;
   logic                    b_ready_o;
   logic [AXI_ID_WIDTH-1:0] ar_id_o;
   logic [ADDR_WIDTH-1:0]   ar_addr_o;
   logic [7:0]              ar_len_o;
   logic [2:0]              ar_size_o;
   logic [1:0]              ar_burst_o;
   logic                    ar_lock_o;
   logic [3:0]              ar_cache_o;
   logic [2:0]              ar_prot_o;
   logic [3:0]              ar_region_o;
   logic [3:0]              ar_qos_o;
   logic [USER_WIDTH-1:0]   ar_user_o;
   logic                    ar_valid_o;
   logic                    ar_ready_i;
   logic [AXI_ID_WIDTH-1:0] r_id_i;
   logic [DATA_WIDTH-1:0]   r_data_i;
   logic [1:0]              r_resp_i;
   logic                    r_last_i;
   logic [USER_WIDTH-1:0]   r_user_i;
   logic                    r_valid_i;
   logic                    r_ready_o;

   modport master (
      output aw_id_o, aw_addr_o, aw_len_o, aw_size_o, aw_burst_o, aw_lock_o, aw_cache_o,
             aw_prot_o, aw_region_o, aw_qos_o, aw_user_o, aw_valid_o,
             w_data_o, w_strb_o, w_last_o, w_user_o, w_valid_o, b_ready_o,
             ar_id_o, ar_addr_o, ar_len_o, ar_size_o, ar_burst_o, ar_lock_o, ar_cache_o,
             ar_prot_o, ar_region_o, ar_qos_o, ar_user_o, ar_valid_o, r_ready_o,
      input  aw_ready_i, w_ready_i, b_id_i, b_resp_i, b_user_i, b_valid_i, ar_ready_i,
             r_id_i, r_data_i, r_resp_i, r_last_i, r_user_i, r_valid_i
   );
   modport slave (
      input  aw_id_o, aw_addr_o, aw_len_o, aw_size_o, aw_burst_o, aw_lock_o, aw_cache_o,
             aw_prot_o, aw_region_o, aw_qos_o, aw_user_o, aw_valid_o,
             w_data_o, w_strb_o, w_last_o, w_user_o, w_valid_o, b_ready_o,
             ar_id_o, ar_addr_o, ar_len_o, ar_size_o, ar_burst_o, ar_lock_o, ar_cache_o,
             ar_prot_o, ar_region_o, ar_qos_o, ar_user_o, ar_valid_o, r_ready_o,
      output aw_ready_i, w_ready_i, b_id_i, b_resp_i, b_user_i, b_valid_i, ar_ready_i,
             r_id_i, r_data_i, r_resp_i, r_last_i, r_user_i, r_valid_i
   );
endinterface

// File: rtl/lint_2_axi_mo.sv
// Multiple-outstanding lint-to-AXI4 bridge: single-beat accesses, in-order responses
// tracked by a FIFO of {we, lane, ID, aux}. Handshake: a channel transfers when valid & ready.
module lint_2_axi_mo #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 64,
   parameter int BE_WIDTH        = 4,
   parameter int ID_WIDTH        = 16,
   parameter int AUX_WIDTH       = 10,
   parameter int USER_WIDTH      = 10,
   parameter int AXI_ID_WIDTH    = 5,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   lint_if.slave lint,
   axi_if.master axi,
   output logic busy_o,
   output logic err_o
);
   localparam int NLANE = DATA_WIDTH / 32;
   localparam int L     = $clog2(DATA_WIDTH / 8) - 2;
   localparam int LW    = (L > 0) ? L : 1;
   localparam int PW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CW    = $clog2(MAX_OUTSTANDING + 1);

   logic [LW-1:0]        fifo_lane [MAX_OUTSTANDING];
   logic                 fifo_we   [MAX_OUTSTANDING];
   logic [ID_WIDTH-1:0]  fifo_id   [MAX_OUTSTANDING];
   logic [AUX_WIDTH-1:0] fifo_aux  [MAX_OUTSTANDING];
   logic [PW-1:0]        wr_ptr, rd_ptr;
   logic [CW-1:0]        count;
   logic                 dir_q, aw_done, w_done;
   logic [LW-1:0]        lane;
   logic                 we, full, can_issue, aw_hs, w_hs, gnt;
   logic                 b_pop, r_pop, pop, head_we;
   logic [DATA_WIDTH/8-1:0] strb;
   logic                 unused;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      nxt = (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
   endfunction

   generate
      if (L > 0) begin : g_lane
         assign lane = lint.data_addr_i[L+1:2];
      end else begin : g_nolane
         assign lane = '0;
      end
   endgenerate

   assign we      = lint.data_we_i;
   assign full    = (count == CW'(MAX_OUTSTANDING));
   // Direction may only change on an empty FIFO so B and R order stays unambiguous with one ID.
   assign can_issue = ~rst_i & lint.data_req_i & ~full & ((count == '0) | (we == dir_q));
   assign aw_hs   = axi.aw_valid_o & axi.aw_ready_i;
   assign w_hs    = axi.w_valid_o & axi.w_ready_i;
   assign gnt     = (axi.ar_valid_o & axi.ar_ready_i)
                  | (can_issue & we & (aw_done | aw_hs) & (w_done | w_hs));
   assign head_we = fifo_we[rd_ptr];
   assign b_pop   = axi.b_valid_i & (count != '0) & head_we;
   assign r_pop   = axi.r_valid_i & (count != '0) & ~head_we;
   assign pop     = b_pop | r_pop;

   always_comb begin
      strb = '0;
      strb[lane*4 +: 4] = lint.data_be_i;
   end

   assign lint.data_gnt_o = gnt;
   assign busy_o          = (count != '0);

   assign axi.aw_valid_o  = can_issue & we & ~aw_done;
   assign axi.w_valid_o   = can_issue & we & ~w_done;
   assign axi.ar_valid_o  = can_issue & ~we;
   assign axi.aw_addr_o   = lint.data_addr_i;
   assign axi.ar_addr_o   = lint.data_addr_i;
   assign axi.w_data_o    = {NLANE{lint.data_wdata_i}};
   assign axi.w_strb_o    = strb;
   assign axi.w_last_o    = 1'b1;
   assign axi.w_user_o    = '0;
   assign axi.b_ready_o   = 1'b1;
   assign axi.r_ready_o   = 1'b1;
   assign axi.aw_id_o     = '0;
   assign axi.aw_len_o    = '0;
   assign axi.aw_size_o   = 3'b010;
   assign axi.aw_burst_o  = 2'b01;
   assign axi.aw_lock_o   = 1'b0;
   assign axi.aw_cache_o  = '0;
   assign axi.aw_prot_o   = '0;
   assign axi.aw_region_o = '0;
   assign axi.aw_qos_o    = '0;
   assign axi.aw_user_o   = '0;
   assign axi.ar_id_o     = '0;
   assign axi.ar_len_o    = '0;
   assign axi.ar_size_o   = 3'b010;
   assign axi.ar_burst_o  = 2'b01;
   assign axi.ar_lock_o   = 1'b0;
   assign axi.ar_cache_o  = '0;
   assign axi.ar_prot_o   = '0;
   assign axi.ar_region_o = '0;
   assign axi.ar_qos_o    = '0;
   assign axi.ar_user_o   = '0;

   assign unused = ^{axi.b_id_i, axi.b_user_i, axi.b_resp_i[0], axi.r_id_i, axi.r_last_i,
                     axi.r_user_i, axi.r_resp_i[0]};

   always_ff @(posedge clk_i) begin
      if (gnt) begin
         fifo_we[wr_ptr]   <= we;
         fifo_lane[wr_ptr] <= lane;
         fifo_id[wr_ptr]   <= lint.data_ID_i;
         fifo_aux[wr_ptr]  <= lint.data_aux_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr             <= '0;
         rd_ptr             <= '0;
         count              <= '0;
         dir_q              <= 1'b0;
         aw_done            <= 1'b0;
         w_done             <= 1'b0;
         lint.data_rvalid_o <= 1'b0;
         lint.data_rdata_o  <= '0;
         lint.data_ropc_o   <= 1'b0;
         lint.data_rID_o    <= '0;
         lint.data_raux_o   <= '0;
         err_o              <= 1'b0;
      end else begin
         if (gnt) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            wr_ptr  <= nxt(wr_ptr);
            dir_q   <= we;
         end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
         end
         if (pop) rd_ptr <= nxt(rd_ptr);
         count              <= count + CW'(gnt) - CW'(pop);
         lint.data_rvalid_o <= pop;
         err_o              <= (axi.b_valid_i & ~b_pop) | (axi.r_valid_i & ~r_pop);
         if (pop) begin
            lint.data_ropc_o <= b_pop ? axi.b_resp_i[1] : axi.r_resp_i[1];
            lint.data_rID_o  <= fifo_id[rd_ptr];
            lint.data_raux_o <= fifo_aux[rd_ptr];
         end
         if (r_pop) lint.data_rdata_o <= axi.r_data_i[fifo_lane[rd_ptr]*32 +: 32];
      end
   end
endmodule
